// File: rtl/stopwatch_pkg.sv
// Shared state encoding, limits and the 7-segment decoder for the stopwatch/timer core.
package stopwatch_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle    = 2'd0;
  localparam state_t StRun     = 2'd1;
  localparam state_t StPause   = 2'd2;
  localparam state_t StExpired = 2'd3;

  localparam int unsigned SEC_MAX   = 59;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;

  // Active-low gfedcba; non-decimal codes blank the digit.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_scan_mux.sv
// Four-digit multiplexed 7-segment scan; outputs decode directly from the scan index so they
// change in the same cycle as the index.
module seg_scan_mux
  import stopwatch_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] bcd_i,
  input  logic [3:0]  dp_mask_i,
  input  logic [3:0]  blank_mask_i,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic [3:0]  an_o
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_TOP = DW'(SCAN_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    digit;

  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DIV_TOP) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q <= '0;
      idx_q <= 2'd0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
    end
  end

  always_comb begin
    digit = bcd_i[{idx_q, 2'b00} +: 4];
    seg_o = blank_mask_i[idx_q] ? SEG_BLANK : bcd_to_seg(digit);
    dp_o  = ~dp_mask_i[idx_q];
    an_o  = ~(4'b0001 << idx_q);
  end

endmodule

// File: rtl/stopwatch_timer_core.sv
// Min:sec stopwatch / countdown timer with preset load, expiry, lap freeze and 4-digit scan.
module stopwatch_timer_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned MAX_MIN  = 59,
  parameter int unsigned SCAN_DIV = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       lap,
  input  logic       mode_down,
  input  logic       load,
  input  logic [6:0] preset_min,
  input  logic [5:0] preset_sec,
  output logic [6:0] min,
  output logic [5:0] sec,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       running,
  output logic       expired
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);

  logic          start_q, stop_q, lap_q;
  logic          start_go, stop_go, lap_go;
  state_t        state_q, state_d;
  logic          mode_q, mode_d;
  logic [6:0]    min_q, min_d, snap_min_q, snap_min_d, t_min, p_min, disp_min;
  logic [5:0]    sec_q, sec_d, snap_sec_q, snap_sec_d, t_sec, p_sec, disp_sec;
  logic          lap_hold_q, lap_hold_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          count_zero;
  logic [15:0]   bcd;

  // Higher-priority events mask lower ones: stop > start > lap.
  assign stop_go  = stop & ~stop_q;
  assign start_go = start & ~start_q & ~stop_go;
  assign lap_go   = lap & ~lap_q & ~stop_go & ~(start & ~start_q);

  assign p_min      = (preset_min > 7'(MAX_MIN)) ? 7'(MAX_MIN) : preset_min;
  assign p_sec      = (preset_sec > 6'(SEC_MAX)) ? 6'(SEC_MAX) : preset_sec;
  assign count_zero = (min_q == 7'd0) && (sec_q == 6'd0);

  always_comb begin
    t_min = min_q;
    t_sec = sec_q;
    if (!mode_q) begin
      if (sec_q == 6'(SEC_MAX)) begin
        t_sec = 6'd0;
        t_min = (min_q == 7'(MAX_MIN)) ? 7'd0 : min_q + 7'd1;
      end else begin
        t_sec = sec_q + 6'd1;
      end
    end else if (sec_q != 6'd0) begin
      t_sec = sec_q - 6'd1;
    end else if (min_q != 7'd0) begin
      t_min = min_q - 7'd1;
      t_sec = 6'(SEC_MAX);
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    min_d      = min_q;
    sec_d      = sec_q;
    lap_hold_d = lap_hold_q;
    snap_min_d = snap_min_q;
    snap_sec_d = snap_sec_q;
    presc_d    = presc_q;
    case (state_q)
      StIdle: begin
        mode_d     = mode_down;
        presc_d    = '0;
        lap_hold_d = 1'b0;
        if (start_go && !(mode_down && count_zero)) state_d = StRun;
        if (load) begin
          min_d = p_min;
          sec_d = p_sec;
        end
      end
      StRun: begin
        if (presc_q == PRESC_TOP) begin
          presc_d = '0;
          min_d   = t_min;
          sec_d   = t_sec;
          if (mode_q && t_min == 7'd0 && t_sec == 6'd0) state_d = StExpired;
        end else begin
          presc_d = presc_q + 1'b1;
        end
        if (stop_go) begin
          state_d = StPause;
        end else if (lap_go) begin
          lap_hold_d = ~lap_hold_q;
          if (!lap_hold_q) begin
            snap_min_d = min_q;
            snap_sec_d = sec_q;
          end
        end
      end
      StPause: begin
        if (stop_go) begin
          state_d    = StIdle;
          lap_hold_d = 1'b0;
          min_d      = mode_q ? p_min : 7'd0;
          sec_d      = mode_q ? p_sec : 6'd0;
        end else if (start_go) begin
          state_d = StRun;
        end
        if (load) begin
          min_d   = p_min;
          sec_d   = p_sec;
          presc_d = '0;
        end
      end
      default: begin
        presc_d = '0;
        min_d   = 7'd0;
        sec_d   = 6'd0;
        if (stop_go) begin
          state_d    = StIdle;
          lap_hold_d = 1'b0;
          min_d      = mode_q ? p_min : 7'd0;
          sec_d      = mode_q ? p_sec : 6'd0;
        end
      end
    endcase
  end

  // Edge registers reset high so a button held through reset must be released before it counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q    <= 1'b1;
      stop_q     <= 1'b1;
      lap_q      <= 1'b1;
      state_q    <= StIdle;
      mode_q     <= 1'b0;
      min_q      <= '0;
      sec_q      <= '0;
      lap_hold_q <= 1'b0;
      snap_min_q <= '0;
      snap_sec_q <= '0;
      presc_q    <= '0;
    end else begin
      start_q    <= start;
      stop_q     <= stop;
      lap_q      <= lap;
      state_q    <= state_d;
      mode_q     <= mode_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      lap_hold_q <= lap_hold_d;
      snap_min_q <= snap_min_d;
      snap_sec_q <= snap_sec_d;
      presc_q    <= presc_d;
    end
  end

  always_comb begin
    disp_min = lap_hold_q ? snap_min_q : min_q;
    disp_sec = lap_hold_q ? snap_sec_q : sec_q;
    bcd      = {4'(disp_min / 7'd10), 4'(disp_min % 7'd10),
                4'(disp_sec / 6'd10), 4'(disp_sec % 6'd10)};
  end

  seg_scan_mux #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk_i        (clk),
    .rst_i        (rst),
    .bcd_i        (bcd),
    .dp_mask_i    ({1'b0, 1'b1, 1'b0, lap_hold_q}),
    .blank_mask_i ({(bcd[15:12] == 4'd0), 3'b000}),
    .seg_o        (seg),
    .dp_o         (dp),
    .an_o         (an)
  );

  assign min     = min_q;
  assign sec     = sec_q;
  assign running = (state_q == StRun);
  assign expired = (state_q == StExpired);

endmodule

// File: tb/tb_stopwatch_timer_core.sv
// Scoreboard bench: stimulus queues expected values, a negedge monitor pops and compares them.
module tb_stopwatch_timer_core;

  localparam int SelMin  = 0;
  localparam int SelSec  = 1;
  localparam int SelRun  = 2;
  localparam int SelExp  = 3;
  localparam int SelAn   = 4;
  localparam int SelSeg  = 5;
  localparam int SelDp   = 6;
  localparam int SelBMin = 7;
  localparam int SelBSec = 8;
  localparam int SelBRun = 9;

  typedef struct {
    int    sel;
    int    exp;
    string name;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic       clk;
  logic       rst;
  logic       start, stop, lap, mode_down, load;
  logic [6:0] preset_min;
  logic [5:0] preset_sec;
  logic [6:0] a_min, a_seg;
  logic [5:0] a_sec;
  logic       a_dp, a_running, a_expired;
  logic [3:0] a_an;

  logic       b_start, b_load, b_zero;
  logic [6:0] b_pmin, b_min, b_seg;
  logic [5:0] b_psec, b_sec;
  logic       b_dp, b_running, b_expired;
  logic [3:0] b_an;

  stopwatch_timer_core #(
    .TICK_DIV (4),
    .MAX_MIN  (59),
    .SCAN_DIV (2)
  ) dut_a (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .lap        (lap),
    .mode_down  (mode_down),
    .load       (load),
    .preset_min (preset_min),
    .preset_sec (preset_sec),
    .min        (a_min),
    .sec        (a_sec),
    .seg        (a_seg),
    .dp         (a_dp),
    .an         (a_an),
    .running    (a_running),
    .expired    (a_expired)
  );

  stopwatch_timer_core #(
    .TICK_DIV (4),
    .MAX_MIN  (1),
    .SCAN_DIV (2)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .start      (b_start),
    .stop       (b_zero),
    .lap        (b_zero),
    .mode_down  (b_zero),
    .load       (b_load),
    .preset_min (b_pmin),
    .preset_sec (b_psec),
    .min        (b_min),
    .sec        (b_sec),
    .seg        (b_seg),
    .dp         (b_dp),
    .an         (b_an),
    .running    (b_running),
    .expired    (b_expired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int actual_of(input int sel);
    case (sel)
      SelMin:  return int'(a_min);
      SelSec:  return int'(a_sec);
      SelRun:  return int'(a_running);
      SelExp:  return int'(a_expired);
      SelAn:   return int'(a_an);
      SelSeg:  return int'(a_seg);
      SelDp:   return int'(a_dp);
      SelBMin: return int'(b_min);
      SelBSec: return int'(b_sec);
      SelBRun: return int'(b_running);
      default: return -1;
    endcase
  endfunction

  initial begin
    exp_t e;
    int   act;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = actual_of(e.sel);
        n_vec++;
        if (act != e.exp) begin
          n_bad++;
          $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", e.name, act, act, e.exp, e.exp);
        end
      end
    end
  end

  task automatic chk(input int sel, input int exp, input string name);
    exp_t e;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Synchronises to a scan slot only; the values shown are checked through the scoreboard.
  task automatic wait_digit(input logic [3:0] which, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (a_an == which) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: an slot %b never seen, last an=%b", name, which, a_an);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(SelMin, 0, {tag, " min"});
    chk(SelSec, 0, {tag, " sec"});
    chk(SelRun, 0, {tag, " running"});
    chk(SelExp, 0, {tag, " expired"});
    chk(SelAn, 4'b1110, {tag, " an"});
    chk(SelSeg, 7'b1000000, {tag, " seg"});
    chk(SelDp, 1, {tag, " dp"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {start, stop, lap, mode_down, load} = '0;
    preset_min = '0;
    preset_sec = '0;
    {b_start, b_load, b_zero} = '0;
    b_pmin = '0;
    b_psec = '0;
    #1;
    chk_reset_outputs("reset");
    step(2);
    rst = 1'b0;
    step(2);

    // MAX_MIN=1 instance: 01:59 wraps to 00:00 and keeps running.
    b_pmin = 7'd1;
    b_psec = 6'd59;
    b_load = 1'b1;
    step(1);
    chk(SelBMin, 1, "wrap preset min");
    chk(SelBSec, 59, "wrap preset sec");
    b_load  = 1'b0;
    b_start = 1'b1;
    step(1);
    chk(SelBRun, 1, "wrap start running");
    b_start = 1'b0;
    step(3);
    chk(SelBSec, 59, "wrap before tick");
    step(1);
    chk(SelBMin, 0, "wrap min");
    chk(SelBSec, 0, "wrap sec");
    chk(SelBRun, 1, "wrap still running");
    step(4);
    chk(SelBSec, 1, "wrap next tick");

    // Up count: first tick 4 cycles after entering RUN, 01:00 after 240.
    start = 1'b1;
    step(1);
    chk(SelRun, 1, "up running");
    chk(SelSec, 0, "up entry sec");
    start = 1'b0;
    step(3);
    chk(SelSec, 0, "up sec before first tick");
    step(1);
    chk(SelSec, 1, "up first tick");
    step(236);
    chk(SelMin, 1, "up 240 min");
    chk(SelSec, 0, "up 240 sec");
    chk(SelRun, 1, "up 240 running");

    stop = 1'b1;
    step(1);
    chk(SelRun, 0, "pause running");
    chk(SelMin, 1, "pause min");
    stop = 1'b0;
    step(1);
    start = 1'b1;
    stop  = 1'b1;
    step(1);
    chk(SelRun, 0, "start+stop running");
    chk(SelMin, 0, "start+stop idle min");
    chk(SelSec, 0, "start+stop idle sec");
    start = 1'b0;
    stop  = 1'b0;
    step(1);

    // Preset clamp.
    preset_min = 7'd120;
    preset_sec = 6'd62;
    load       = 1'b1;
    step(1);
    chk(SelMin, 59, "clamp min");
    chk(SelSec, 59, "clamp sec");
    load = 1'b0;

    // Countdown from 00:03.
    mode_down  = 1'b1;
    preset_min = 7'd0;
    preset_sec = 6'd3;
    load       = 1'b1;
    step(1);
    chk(SelSec, 3, "down load sec");
    load = 1'b0;
    step(1);
    start = 1'b1;
    step(1);
    chk(SelRun, 1, "down running");
    start = 1'b0;
    step(11);
    chk(SelSec, 1, "down sec at 11");
    chk(SelExp, 0, "down not yet expired");
    step(1);
    chk(SelSec, 0, "down sec at 12");
    chk(SelExp, 1, "down expired");
    chk(SelRun, 0, "down expired running");
    step(8);
    chk(SelSec, 0, "expired holds sec");
    chk(SelExp, 1, "expired holds");
    start = 1'b1;
    step(1);
    chk(SelExp, 1, "expired ignores start");
    start = 1'b0;
    step(1);
    stop = 1'b1;
    step(1);
    chk(SelExp, 0, "expired stop clears flag");
    chk(SelSec, 3, "expired stop reloads sec");
    chk(SelMin, 0, "expired stop reloads min");
    stop = 1'b0;
    step(1);

    // Lap hold: snapshot 00:05 stays on display while the count runs to 00:13.
    mode_down  = 1'b0;
    preset_sec = 6'd0;
    load       = 1'b1;
    step(1);
    chk(SelSec, 0, "lap clear sec");
    load  = 1'b0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(20);
    chk(SelSec, 5, "lap sec at snapshot");
    lap = 1'b1;
    step(1);
    lap = 1'b0;
    step(31);
    chk(SelSec, 13, "lap live sec");
    stop = 1'b1;
    step(1);
    chk(SelRun, 0, "lap paused");
    stop = 1'b0;
    wait_digit(4'b1110, "lap digit0");
    chk(SelSeg, 7'b0010010, "lap digit0 seg");
    chk(SelDp, 0, "lap digit0 dp");
    chk(SelSec, 13, "lap digit0 live sec");
    wait_digit(4'b1101, "lap digit1");
    chk(SelSeg, 7'b1000000, "lap digit1 seg");
    chk(SelDp, 1, "lap digit1 dp");
    wait_digit(4'b1011, "lap digit2");
    chk(SelSeg, 7'b1000000, "lap digit2 seg");
    chk(SelDp, 0, "lap digit2 dp");
    wait_digit(4'b0111, "lap digit3");
    chk(SelSeg, 7'h7F, "lap digit3 blank");

    start = 1'b1;
    step(1);
    chk(SelRun, 1, "resume running");
    start = 1'b0;
    lap   = 1'b1;
    step(1);
    lap  = 1'b0;
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk(SelSec, 13, "second lap sec");
    wait_digit(4'b1110, "live digit0");
    chk(SelSeg, 7'b0110000, "live digit0 seg");
    chk(SelDp, 1, "live digit0 dp");

    // Asynchronous reset mid-run, with start held high through release.
    start = 1'b1;
    step(6);
    chk(SelRun, 1, "pre-reset running");
    step(1);
    rst = 1'b1;
    chk_reset_outputs("async reset");
    step(2);
    rst = 1'b0;
    step(3);
    chk(SelRun, 0, "held start after reset");
    start = 1'b0;
    step(1);
    start = 1'b1;
    step(1);
    chk(SelRun, 1, "fresh start after reset");
    start = 1'b0;

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
